// File: rtl/adc_spi_capture.sv
// adc_spi_capture: periodic SPI master for a 12-bit AD7476-style ADC.
// Emits each captured word as a registered one-cycle sample/valid strobe.
module adc_spi_capture #(
  parameter int CLK_DIV       = 1,
  parameter int SAMPLE_PERIOD = 64,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_W        = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              P_SDATA,
  output logic              P_SCLK,
  output logic              P_nCS,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HIGH, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           per_q, per_d;
  logic [HW-1:0]           half_q, half_d;
  logic [BW-1:0]           bits_q, bits_d;
  logic                    sclk_q, sclk_d;
  logic                    ncs_q, ncs_d;
  logic                    busy_q, busy_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d, sr_nxt;
  logic [1:0]              pipe_q, pipe_d;
  logic [DATA_W-1:0]       smp_q, smp_d;
  logic                    err_q, err_d;
  logic                    vld_q, vld_d;
  logic                    meta_q, sync_q;
  logic                    half_end;

  // Shift strobe trails the rising edge by the synchroniser depth,
  // so the bit shifted in is the line value just before P_SCLK rose.
  assign sr_nxt = pipe_q[1] ? {sr_q[FRAME_BITS-2:0], sync_q} : sr_q;
  assign half_end = (half_q == HW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    per_d   = '0;
    half_d  = half_q;
    bits_d  = bits_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    sr_d    = sr_nxt;
    pipe_d  = {pipe_q[0], 1'b0};
    smp_d   = smp_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    if (en) begin
      if (per_q != PW'(SAMPLE_PERIOD - 1)) per_d = per_q + PW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (en && per_q == '0) begin
          ncs_d   = 1'b0;
          half_d  = '0;
          bits_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (half_end) begin
          sclk_d  = 1'b0;
          half_d  = '0;
          state_d = LOW;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      LOW: begin
        if (half_end) begin
          sclk_d    = 1'b1;
          half_d    = '0;
          bits_d    = bits_q + BW'(1);
          pipe_d[0] = 1'b1;
          state_d   = HIGH;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      HIGH: begin
        if (half_end) begin
          half_d = '0;
          if (bits_q < BW'(FRAME_BITS)) begin
            sclk_d  = 1'b0;
            state_d = LOW;
          end else begin
            ncs_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      DONE: begin
        vld_d   = 1'b1;
        smp_d   = sr_nxt[DATA_W-1:0];
        err_d   = |sr_nxt[FRAME_BITS-1:DATA_W];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = ~ncs_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      half_q  <= '0;
      bits_q  <= '0;
      sclk_q  <= 1'b1;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      sr_q    <= '0;
      pipe_q  <= '0;
      smp_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      half_q  <= half_d;
      bits_q  <= bits_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      sr_q    <= sr_d;
      pipe_q  <= pipe_d;
      smp_q   <= smp_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      meta_q  <= P_SDATA;
      sync_q  <= meta_q;
    end
  end

  assign P_SCLK       = sclk_q;
  assign P_nCS        = ncs_q;
  assign busy         = busy_q;
  assign sample       = smp_q;
  assign frame_err    = err_q;
  assign sample_valid = vld_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: scoreboard bench with a behavioural ADC model.
// Two DUTs: defaults, and CLK_DIV=3 / SAMPLE_PERIOD=128.
module tb_adc_spi_capture;

  typedef struct packed {
    logic [11:0] s;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, en_b;
  logic        sd_a, sd_b;
  logic        sclk_a, ncs_a, vld_a, err_a, busy_a;
  logic        sclk_b, ncs_b, vld_b, err_b, busy_b;
  logic [11:0] smp_a, smp_b;

  adc_spi_capture dut_a (
    .clk(clk), .rst(rst), .en(en_a), .P_SDATA(sd_a),
    .P_SCLK(sclk_a), .P_nCS(ncs_a), .sample(smp_a),
    .sample_valid(vld_a), .frame_err(err_a), .busy(busy_a)
  );

  adc_spi_capture #(.CLK_DIV(3), .SAMPLE_PERIOD(128)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .P_SDATA(sd_b),
    .P_SCLK(sclk_b), .P_nCS(ncs_b), .sample(smp_b),
    .sample_valid(vld_b), .frame_err(err_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] s, input logic e);
    exp_t r;
    r.s = s;
    r.e = e;
    return r;
  endfunction

  // ADC model: new bit presented after each P_SCLK fall, MSB first
  logic [15:0] adc_qa[$], adc_qb[$];
  logic [15:0] word_a, word_b;
  int k_a = 0, k_b = 0;
  initial begin sd_a = 1'b1; sd_b = 1'b1; end

  always @(negedge ncs_a) begin
    word_a = (adc_qa.size() != 0) ? adc_qa.pop_front() : 16'hFFFF;
    k_a = 0;
  end
  always @(negedge sclk_a) if (ncs_a === 1'b0 && k_a < 16) begin
    sd_a = word_a[15-k_a];
    k_a++;
  end
  always @(posedge ncs_a) sd_a = 1'b1;

  always @(negedge ncs_b) begin
    word_b = (adc_qb.size() != 0) ? adc_qb.pop_front() : 16'hFFFF;
    k_b = 0;
  end
  always @(negedge sclk_b) if (ncs_b === 1'b0 && k_b < 16) begin
    sd_b = word_b[15-k_b];
    k_b++;
  end
  always @(posedge ncs_b) sd_b = 1'b1;

  // Scoreboards
  exp_t exp_qa[$], exp_qb[$];
  exp_t e_a, e_b;
  int   cyc = 0;
  int   last_vld_a = -1;
  int   vld_cnt_a = 0, vld_cnt_b = 0;
  logic gap_a_en = 1'b0;
  logic vld_pa = 1'b0, vld_pb = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (vld_a === 1'b1) begin
      chk("sb_pending_a", exp_qa.size() > 0, 1);
      if (exp_qa.size() > 0) begin
        e_a = exp_qa.pop_front();
        chk("sample_a", smp_a, e_a.s);
        chk("frame_err_a", err_a, e_a.e);
      end
      if (gap_a_en && last_vld_a >= 0)
        chk("valid_gap_a", cyc - last_vld_a, 64);
      chk("valid_pulse_a", vld_pa, 0);
      last_vld_a = cyc;
      vld_cnt_a++;
    end
    vld_pa = vld_a;
  end

  always @(negedge clk) begin
    if (vld_b === 1'b1) begin
      chk("sb_pending_b", exp_qb.size() > 0, 1);
      if (exp_qb.size() > 0) begin
        e_b = exp_qb.pop_front();
        chk("sample_b", smp_b, e_b.s);
        chk("frame_err_b", err_b, e_b.e);
      end
      chk("valid_pulse_b", vld_pb, 0);
      vld_cnt_b++;
    end
    vld_pb = vld_b;
  end

  // Frame shape monitors
  int   low_a = 0, rises_a = 0, falls_a = 0;
  logic sclk_pa = 1'b1, ncs_pa = 1'b1, frame_chk_a = 1'b1;

  always @(negedge clk) begin
    if (ncs_a === 1'b0) begin
      low_a++;
      if (sclk_a && !sclk_pa) rises_a++;
      if (ncs_pa) falls_a++;
    end else if (ncs_a === 1'b1 && ncs_pa === 1'b0 && frame_chk_a) begin
      chk("rises_a", rises_a, 16);
      chk("ncs_low_a", low_a, 33);
    end
    if (ncs_a !== 1'b0) begin low_a = 0; rises_a = 0; end
    sclk_pa = sclk_a;
    ncs_pa  = ncs_a;
  end

  int   low_b = 0, rises_b = 0, falls_b = 0, run_b = 0;
  logic sclk_pb = 1'b1, ncs_pb = 1'b1;

  always @(negedge clk) begin
    if (ncs_b === 1'b0) begin
      low_b++;
      if (ncs_pb) begin
        falls_b++;
        run_b = 1;
      end else if (sclk_b != sclk_pb) begin
        chk("half_period_b", run_b, 3);
        run_b = 1;
      end else begin
        run_b++;
      end
      if (sclk_b && !sclk_pb) rises_b++;
    end else if (ncs_b === 1'b1 && ncs_pb === 1'b0) begin
      chk("rises_b", rises_b, 16);
      chk("ncs_low_b", low_b, 99);
    end
    if (ncs_b !== 1'b0) begin low_b = 0; rises_b = 0; end
    sclk_pb = sclk_b;
    ncs_pb  = ncs_b;
  end

  task automatic drain_a(input int max);
    for (int i = 0; i < max && exp_qa.size() != 0; i++) @(negedge clk);
    chk("drain_a", exp_qa.size(), 0);
  endtask

  task automatic drain_b(input int max);
    for (int i = 0; i < max && exp_qb.size() != 0; i++) @(negedge clk);
    chk("drain_b", exp_qb.size(), 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int f0, v0;
  logic [15:0] words[6];
  initial begin
    words = '{16'h0ABC, 16'h0000, 16'h0FFF, 16'h0555, 16'h0AAA, 16'h0001};
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs_a, 1);
    chk("rst_sclk", sclk_a, 1);
    chk("rst_sample", smp_a, 0);
    chk("rst_valid", vld_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 0);
    rst = 1'b0;

    // 0x0ABC then four-pattern run, periodic spacing
    f0 = falls_a; v0 = vld_cnt_a;
    foreach (words[i]) begin
      adc_qa.push_back(words[i]);
      exp_qa.push_back(mk(words[i][11:0], 1'b0));
    end
    gap_a_en = 1'b1;
    en_a = 1'b1;
    for (int i = 0; i < 500 && falls_a < f0 + 6; i++) @(negedge clk);
    chk("frames_started", falls_a - f0, 6);
    en_a = 1'b0;
    drain_a(100);
    gap_a_en = 1'b0;
    chk("valid_count_run", vld_cnt_a - v0, 6);

    // Leading one flags frame_err; en dropped at bit 3
    f0 = falls_a; v0 = vld_cnt_a;
    adc_qa.push_back(16'h8123);
    exp_qa.push_back(mk(12'h123, 1'b1));
    en_a = 1'b1;
    for (int i = 0; i < 100 && !(ncs_a === 1'b0 && rises_a >= 3); i++)
      @(negedge clk);
    chk("busy_mid_frame", busy_a, 1);
    en_a = 1'b0;
    drain_a(100);
    repeat (200) @(negedge clk);
    chk("no_frame_after_en_drop", falls_a - f0, 1);
    chk("valid_count_en_drop", vld_cnt_a - v0, 1);
    chk("sample_hold", smp_a, 12'h123);
    chk("err_hold", err_a, 1);
    chk("busy_idle", busy_a, 0);

    // Reset at the 7th rising edge aborts the frame
    frame_chk_a = 1'b0;
    f0 = falls_a; v0 = vld_cnt_a;
    adc_qa.push_back(16'h0F0F);
    en_a = 1'b1;
    for (int i = 0; i < 100 && !(ncs_a === 1'b0 && rises_a >= 7); i++)
      @(negedge clk);
    chk("abort_at_bit7", rises_a, 7);
    rst = 1'b1; en_a = 1'b0;
    @(negedge clk);
    chk("abort_ncs", ncs_a, 1);
    chk("abort_sclk", sclk_a, 1);
    chk("abort_valid", vld_a, 0);
    chk("abort_busy", busy_a, 0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_no_valid", vld_cnt_a - v0, 0);
    frame_chk_a = 1'b1;
    adc_qa.push_back(16'h0321);
    exp_qa.push_back(mk(12'h321, 1'b0));
    en_a = 1'b1;
    for (int i = 0; i < 100 && falls_a < f0 + 2; i++) @(negedge clk);
    en_a = 1'b0;
    drain_a(100);
    chk("valid_count_after_abort", vld_cnt_a - v0, 1);

    // Slow clock divider instance
    adc_qb.push_back(16'h07E5);
    exp_qb.push_back(mk(12'h7E5, 1'b0));
    en_b = 1'b1;
    for (int i = 0; i < 200 && falls_b < 1; i++) @(negedge clk);
    en_b = 1'b0;
    drain_b(200);
    chk("valid_count_b", vld_cnt_b, 1);
    chk("frames_b", falls_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
